// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU calculator: op codes, FSM states, widths.
package alu_pkg;

  localparam int DATA_W  = 8;
  localparam int SHAMT_W = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_ASR = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_exec_unit.sv
// Combinational ALU: op/x/y/imm -> {carry, out}. Codes 1010-1110 produce zero.
module alu_exec_unit #(
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W:0]   res
);
  import alu_pkg::*;

  localparam int SH_W = $clog2(DATA_W);

  always_comb begin
    res = '0;
    case (op)
      OP_ADD: res = {1'b0, x} + {1'b0, y};
      // Subtraction wraps in 9 bits, so the top bit is the borrow.
      OP_SUB: res = {1'b0, x} - {1'b0, y};
      OP_AND: res = {1'b0, x & y};
      OP_OR:  res = {1'b0, x | y};
      OP_NOT: res = {1'b0, ~x};
      OP_XOR: res = {1'b0, x ^ y};
      OP_NOR: res = {1'b0, ~(x | y)};
      OP_SHL: res = {1'b0, y} << x[SH_W-1:0];
      OP_SHR: res = {1'b0, y >> x[SH_W-1:0]};
      OP_ASR: res = {1'b0, x[DATA_W-1], x[DATA_W-1:1]};
      OP_LDI: res = {1'b0, imm};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_calc.sv
// Multicycle register-file calculator (IDLE->READ->EXEC->WB) around alu_exec_unit.
// Optional out_zero result flag enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_seq_calc #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int REG_N  = 8,
  parameter int ADDR_W = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic [DATA_W-1:0] imm,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_carry
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic              out_zero
`endif
);
  import alu_pkg::*;

  state_t state, state_nxt;

  logic [DATA_W-1:0] regs [REG_N];
  logic [3:0]        op_p0;
  logic [ADDR_W-1:0] src_a_p0, src_b_p0, dst_p0;
  logic [DATA_W-1:0] imm_p0;
  logic [DATA_W-1:0] x_p1, y_p1;
  logic [DATA_W:0]   alu_res;
  logic [DATA_W:0]   res_p2;

  // Register 0 reads as zero regardless of storage contents.
  function automatic logic [DATA_W-1:0] rd_reg(input logic [ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0] val);
    return (addr == '0) ? '0 : val;
  endfunction

  alu_exec_unit #(.DATA_W(DATA_W)) u_exec (
    .op  (op_p0),
    .x   (x_p1),
    .y   (y_p1),
    .imm (imm_p0),
    .res (alu_res)
  );

  assign in_ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_READ;
      S_READ:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      out_zero  <= 1'b0;
`endif
    end else begin
      // p0: request capture
      if (state == S_IDLE && in_valid) begin
        op_p0    <= op;
        src_a_p0 <= src_a;
        src_b_p0 <= src_b;
        dst_p0   <= dst;
        imm_p0   <= imm;
      end
      // p1: operand read
      if (state == S_READ) begin
        x_p1 <= rd_reg(src_a_p0, regs[src_a_p0]);
        y_p1 <= rd_reg(src_b_p0, regs[src_b_p0]);
      end
      // p2: execute
      if (state == S_EXEC) res_p2 <= alu_res;
      // writeback and result pulse
      out_valid <= (state == S_WB);
      if (state == S_WB) begin
        if (dst_p0 != '0) regs[dst_p0] <= res_p2[DATA_W-1:0];
        out_data  <= res_p2[DATA_W-1:0];
        out_carry <= res_p2[DATA_W];
`ifdef ALU_SEQ_ZERO_FLAG_EN
        out_zero  <= (res_p2[DATA_W-1:0] == '0);
`endif
      end
    end
  end

endmodule

// File: doc/alu_seq_calc.md
Name: alu_seq_calc

Overview:
- Multicycle calculator that sits on the result side of the 8-bit ALU.
- Accepts one instruction per request through a valid/ready handshake.
- Reads two operands from an internal register file, executes them with the team's 4-bit ALU op encoding, and writes the result back.
- Reports each result and its carry with a one-cycle out_valid pulse, so a host can chain ALU operations without driving raw operands.

Parameters:
- DATA_W, 8, datapath width; the bench exercises only 8.
- REG_N, 8, number of registers.
- ADDR_W, 3, register address width, equal to clog2(REG_N).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request strobe.
- in_ready  output  1  high only in IDLE.
- op  input  4  ALU op code, or 1111 for load-immediate.
- src_a  input  ADDR_W  x operand register.
- src_b  input  ADDR_W  y operand register.
- dst  input  ADDR_W  destination register.
- imm  input  DATA_W  immediate value for op 1111.
- out_valid  output  1  one-cycle result pulse.
- out_data  output  DATA_W  result written to dst.
- out_carry  output  1  carry/borrow bit of the result.

Behaviour:
- Reset (clk edge while rst=1):
  - state=IDLE; all registers = 0.
  - out_valid=0, out_data=0, out_carry=0, in_ready=1.
  - rst wins over any in-flight op; that op's writeback is discarded.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
  - IDLE: in_ready=1. On in_valid=1, latch op, src_a, src_b, dst and imm, then go to READ.
  - READ: latch x = reg[src_a] and y = reg[src_b].
  - EXEC: register the 9-bit result {c, r}.
  - WB: write r to reg[dst]; drive out_valid=1 with out_data=r and out_carry=c for exactly 1 cycle.
- Latency: a request accepted at edge t produces out_valid during the cycle after edge t+3. Throughput is one op per 4 cycles.
- in_valid outside IDLE is ignored, not queued; the requester must hold it until it sees in_ready.
- out_data and out_carry hold their last values while out_valid=0.
- Register 0 is hard-wired to 0:
  - reads return 0;
  - writes to dst=0 are dropped, but out_valid still pulses with the computed value.
- Operand capture happens in READ, so a write in WB is visible to the next op (no hazard).
- ALU ops; all results are 9-bit {carry, out}:
  - 0000: x+y.
  - 0001: x-y, 9-bit two's complement; carry=1 means borrow.
  - 0010: x&y.
  - 0011: x|y.
  - 0100: ~x.
  - 0101: x^y.
  - 0110: ~(x|y).
  - 0111: y<<x[2:0], computed 9 bits wide; carry = bit 8.
  - 1000: y>>x[2:0].
  - 1001: {x[7], x[7:1]}.
  - Logic ops 0010-0110 and ops 1000-1001: carry=0.
  - 1010-1110: result 0, carry 0.
  - 1111: result=imm, carry=0.

Optional Feature:
- Macro: ALU_SEQ_ZERO_FLAG_EN.
- Defined: adds output port out_zero (1 bit), registered alongside out_data. out_zero=1 iff out_data==0, regardless of carry. It resets to 0 and holds its value between pulses.
- Undefined: no out_zero port and no extra logic; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit op code constants (OP_ADD ... OP_ASR = 1001, OP_LDI = 1111);
  - the FSM state encoding (2 bits);
  - DATA_W and SHAMT_W = clog2(DATA_W).
- One sub-module, alu_exec_unit: a purely combinational op/x/y/imm -> {carry, out} function, reused by the block's ALU-level bench. The FSM and register file stay in alu_seq_calc.

Test Plan:
- Reset, then LDI r1=0xFF and LDI r2=0x18; ADD dst=r3 src_a=r1 src_b=r2 -> out_data=0x17, out_carry=1, out_valid exactly 4 cycles after acceptance.
- LDI r1=0x05, r2=0x0A; SUB r3=r1-r2 -> out_data=0xFB, out_carry=1. Then SUB r4=r2-r1 -> 0x05, carry 0.
- LDI r1=0x0A, r2=0x05:
  - SHL (0111) -> 0x14, carry 0;
  - SHR (1000) -> 0x01;
  - ASR (1001) with r1=0x8A -> 0xC5, carry 0.
- Hold in_valid=1 with a second op during READ/EXEC/WB -> in_ready=0 and the op is not accepted; it is accepted on return to IDLE, with back-to-back results exactly 4 cycles apart.
- LDI dst=r0 imm=0x3C -> out_data=0x3C pulses, then ADD r5=r0+r0 -> 0x00. With ALU_SEQ_ZERO_FLAG_EN defined, out_zero=1 on that pulse.
- Assert rst during EXEC of an ADD writing r6 -> no out_valid, outputs 0, and a following ADD reading r6 sees 0.
